serial_alu_sequencer: RTL and testbench

//  Bit-serial arithmetic unit. It feeds WIDTH-bit operands LSB-first through
//  an internal 1-bit arithmetic slice (AND/OR/ADD/SUB), carrying between bits.
//  It reassembles the bits into a parallel result.

---
 rtl/serial_alu_sequencer.sv | 145 ++++++++++++++
 tb/tb_serial_alu_sequencer.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_alu_sequencer.sv
// Bit-serial AND/OR/ADD/SUB unit: operands latched on start, processed LSB-first one bit per clock.
// Latency: WIDTH edges from the accepting edge to done; one op every WIDTH+2 cycles back-to-back.
// Backpressure: start is sampled only in IDLE and never queued; busy/done tell the controller when to retry.
module serial_alu_sequencer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             overflow
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    localparam logic [1:0] OP_AND = 2'b00;
    localparam logic [1:0] OP_OR  = 2'b01;
    localparam logic [1:0] OP_ADD = 2'b10;
    localparam logic [1:0] OP_SUB = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] res_sh;
    logic [WIDTH-1:0] res_shifted;
    logic [1:0]       op_q;
    logic [CW-1:0]    cnt;
    logic             carry;

    logic accept;
    logic last_step;
    logic b_eff;
    logic res_bit;
    logic carry_nxt;

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        last_step = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (cnt == LAST_BIT) begin
                    last_step = 1'b1;
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    assign busy = (state == ST_SHIFT);
    assign done = (state == ST_DONE);

    // ------------------------------------------------------------------
    // One-bit arithmetic slice; subtraction is a + ~b + 1 with carry seeded to 1
    // ------------------------------------------------------------------
    always_comb begin
        b_eff     = (op_q == OP_SUB) ? ~b_sh[0] : b_sh[0];
        res_bit   = 1'b0;
        carry_nxt = 1'b0;
        case (op_q)
            OP_AND: res_bit = a_sh[0] & b_sh[0];
            OP_OR:  res_bit = a_sh[0] | b_sh[0];
            default: begin
                res_bit   = a_sh[0] ^ b_eff ^ carry;
                carry_nxt = (a_sh[0] & b_eff) | (a_sh[0] & carry) | (b_eff & carry);
            end
        endcase
    end

    assign res_shifted = {res_bit, res_sh[WIDTH-1:1]};

    // ------------------------------------------------------------------
    // Datapath: operand shifters, result assembly, flags
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            a_sh      <= '0;
            b_sh      <= '0;
            res_sh    <= '0;
            op_q      <= OP_AND;
            cnt       <= '0;
            carry     <= 1'b0;
            result    <= '0;
            carry_out <= 1'b0;
            overflow  <= 1'b0;
        end else if (accept) begin
            a_sh   <= a;
            b_sh   <= b;
            res_sh <= '0;
            op_q   <= op;
            cnt    <= '0;
            carry  <= (op == OP_SUB);
        end else if (state == ST_SHIFT) begin
            a_sh   <= a_sh >> 1;
            b_sh   <= b_sh >> 1;
            res_sh <= res_shifted;
            carry  <= carry_nxt;
            cnt    <= cnt + CW'(1);
            // Outputs only move on the final step so nothing partial is ever visible.
            if (last_step) begin
                result    <= res_shifted;
                carry_out <= carry_nxt;
                overflow  <= carry ^ carry_nxt;
            end
        end
    end

endmodule

// File: tb/tb_serial_alu_sequencer.sv
// Randomized and directed bench for serial_alu_sequencer at WIDTH=8 and WIDTH=2,
// scored against a word-level arithmetic reference model.
module tb_serial_alu_sequencer;

    logic       clk = 1'b0;
    logic       rst;

    logic       start8, busy8, done8, cout8, ovf8;
    logic [1:0] op8;
    logic [7:0] a8, b8, res8;

    logic       start2, busy2, done2, cout2, ovf2;
    logic [1:0] op2;
    logic [1:0] a2, b2, res2;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] last_res8 = 0;
    logic [31:0] last_res2 = 0;

    always #5 clk = ~clk;

    serial_alu_sequencer #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .op(op8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .result(res8), .carry_out(cout8), .overflow(ovf8)
    );

    serial_alu_sequencer #(.WIDTH(2)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .op(op2), .a(a2), .b(b2),
        .busy(busy2), .done(done2), .result(res2), .carry_out(cout2), .overflow(ovf2)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Word-level reference: returns {overflow, carry_out, result[31:0]}
    function automatic logic [33:0] ref_op(input int w, input logic [1:0] op,
                                           input logic [31:0] a, input logic [31:0] b);
        logic [63:0] mask, s, r;
        logic        c, ov;
        mask = (64'd1 << w) - 64'd1;
        r = 0; c = 1'b0; ov = 1'b0;
        case (op)
            2'b00: r = {32'd0, a & b} & mask;
            2'b01: r = {32'd0, a | b} & mask;
            2'b10: begin
                s  = {32'd0, a} + {32'd0, b};
                r  = s & mask;
                c  = s[w];
                ov = (a[w-1] == b[w-1]) && (r[w-1] != a[w-1]);
            end
            default: begin
                r  = ({32'd0, a} - {32'd0, b}) & mask;
                c  = (a >= b);
                ov = (a[w-1] != b[w-1]) && (r[w-1] != a[w-1]);
            end
        endcase
        return {ov, c, r[31:0]};
    endfunction

    function automatic logic [33:0] obs(input int w);
        if (w == 8) return {ovf8, cout8, 24'd0, res8};
        return {ovf2, cout2, 30'd0, res2};
    endfunction

    function automatic logic obs_done(input int w);
        return (w == 8) ? done8 : done2;
    endfunction

    function automatic logic obs_busy(input int w);
        return (w == 8) ? busy8 : busy2;
    endfunction

    task automatic scramble();
        op8 = 2'($urandom); a8 = 8'($urandom); b8 = 8'($urandom);
        op2 = 2'($urandom); a2 = 2'($urandom); b2 = 2'($urandom);
    endtask

    // Issues one op from IDLE (caller is at a negedge) and checks latency, outputs and pulse width.
    task automatic run_op(input string tag, input int w, input logic [1:0] op,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] er, input logic ec, input logic eov);
        int lat;
        logic [31:0] prev;
        logic [33:0] o;
        prev = (w == 8) ? last_res8 : last_res2;
        if (w == 8) begin
            start8 = 1'b1; op8 = op; a8 = a[7:0]; b8 = b[7:0];
        end else begin
            start2 = 1'b1; op2 = op; a2 = a[1:0]; b2 = b[1:0];
        end
        @(negedge clk);
        start8 = 1'b0; start2 = 1'b0;
        scramble();
        lat = 0;
        while (!obs_done(w) && lat <= w + 3) begin
            if (lat == w / 2) begin
                o = obs(w);
                check({tag, "_busy"}, 32'(obs_busy(w)), 32'd1);
                check({tag, "_hold"}, o[31:0], prev);
            end
            @(negedge clk);
            lat++;
        end
        check({tag, "_lat"}, 32'(lat), 32'(w));
        o = obs(w);
        check({tag, "_res"}, o[31:0], er);
        check({tag, "_cout"}, 32'(o[32]), 32'(ec));
        check({tag, "_ovf"}, 32'(o[33]), 32'(eov));
        if (w == 8) last_res8 = er; else last_res2 = er;
        @(negedge clk);
        check({tag, "_pulse"}, 32'(obs_done(w)), 32'd0);
    endtask

    task automatic run_model(input string tag, input int w, input logic [1:0] op,
                             input logic [31:0] a, input logic [31:0] b);
        logic [33:0] e;
        e = ref_op(w, op, a, b);
        run_op(tag, w, op, a, b, e[31:0], e[32], e[33]);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    logic [1:0]  op_h [30];
    logic [7:0]  a_h  [30];
    logic [7:0]  b_h  [30];

    initial begin
        logic [33:0] e;
        int n_done;
        int j;
        int k;
        logic [31:0] ra, rb;

        // Reset with start asserted
        rst = 1'b1;
        start8 = 1'b1; start2 = 1'b1;
        scramble();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_busy8", 32'(busy8), 32'd0);
        check("rst_done8", 32'(done8), 32'd0);
        check("rst_res8",  32'(res8),  32'd0);
        check("rst_cout8", 32'(cout8), 32'd0);
        check("rst_ovf8",  32'(ovf8),  32'd0);
        check("rst_busy2", 32'(busy2), 32'd0);
        check("rst_res2",  32'(res2),  32'd0);
        rst = 1'b0;
        start8 = 1'b0; start2 = 1'b0;
        @(negedge clk);

        // Directed WIDTH=8 cases with hand-derived expectations
        run_op("add_7f_01", 8, 2'b10, 32'h7F, 32'h01, 32'h80, 1'b0, 1'b1);
        run_op("add_ff_01", 8, 2'b10, 32'hFF, 32'h01, 32'h00, 1'b1, 1'b0);
        run_op("sub_05_07", 8, 2'b11, 32'h05, 32'h07, 32'hFE, 1'b0, 1'b0);
        run_op("sub_80_01", 8, 2'b11, 32'h80, 32'h01, 32'h7F, 1'b1, 1'b1);
        run_op("and_f0_3c", 8, 2'b00, 32'hF0, 32'h3C, 32'h30, 1'b0, 1'b0);
        run_op("or_f0_3c",  8, 2'b01, 32'hF0, 32'h3C, 32'hFC, 1'b0, 1'b0);

        // Random WIDTH=8 ops
        for (int i = 0; i < 30; i++) begin
            ra = 32'($urandom_range(0, 255));
            rb = 32'($urandom_range(0, 255));
            run_model("rnd8", 8, 2'($urandom), ra, rb);
        end

        // Start held high for 30 cycles, operands changing every cycle
        n_done = 0;
        for (j = 0; j <= 30; j++) begin
            if (j > 0) begin
                check("held_done", 32'(done8), 32'((j % 10) == 9));
                if (done8) begin
                    n_done++;
                    k = j - 9;
                    if (k >= 0) begin
                        e = ref_op(8, op_h[k], {24'd0, a_h[k]}, {24'd0, b_h[k]});
                        check("held_res",  32'(res8),  e[31:0]);
                        check("held_cout", 32'(cout8), 32'(e[32]));
                        check("held_ovf",  32'(ovf8),  32'(e[33]));
                        last_res8 = e[31:0];
                    end
                end
            end
            if (j < 30) begin
                scramble();
                start8 = 1'b1;
                op_h[j] = op8; a_h[j] = a8; b_h[j] = b8;
                @(negedge clk);
            end
        end
        start8 = 1'b0;
        check("held_count", 32'(n_done), 32'd3);
        @(negedge clk);
        check("held_idle", 32'(busy8), 32'd0);

        // Reset while bit 4 is being processed
        start8 = 1'b1; op8 = 2'b10; a8 = 8'h55; b8 = 8'h33;
        @(negedge clk);
        start8 = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy", 32'(busy8), 32'd0);
        check("abort_done", 32'(done8), 32'd0);
        check("abort_res",  32'(res8),  32'd0);
        check("abort_cout", 32'(cout8), 32'd0);
        check("abort_ovf",  32'(ovf8),  32'd0);
        last_res8 = 0; last_res2 = 0;
        n_done = 0;
        for (int i = 0; i < 12; i++) begin
            if (done8) n_done++;
            @(negedge clk);
        end
        check("abort_no_done", 32'(n_done), 32'd0);

        // Exhaustive WIDTH=2
        for (int o = 0; o < 4; o++)
            for (int x = 0; x < 4; x++)
                for (int y = 0; y < 4; y++)
                    run_model("exh2", 2, 2'(o), 32'(x), 32'(y));

        // A few more WIDTH=8 ops after the abort
        for (int i = 0; i < 8; i++) begin
            ra = 32'($urandom_range(0, 255));
            rb = 32'($urandom_range(0, 255));
            run_model("rnd8b", 8, 2'($urandom), ra, rb);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
